// File: rtl/seq_shift_add_multiplier_if.sv
// Start/done handshake bundle for seq_shift_add_multiplier.
// The master drives the operands and start, and the slave returns busy, done and product.
interface seq_shift_add_multiplier_if #(
  parameter int WIDTH = 8
);
  logic                 start;
  logic [WIDTH-1:0]     a;
  logic [WIDTH-1:0]     b;
  logic                 signed_mode;
  logic                 busy;
  logic                 done;
  logic [2*WIDTH-1:0]   product;

  modport master (
    output start, a, b, signed_mode,
    input  busy, done, product
  );

  modport slave (
    input  start, a, b, signed_mode,
    output busy, done, product
  );
endinterface

// File: rtl/seq_shift_add_multiplier.sv
// Multi-cycle shift-add multiplier that adds one partial product per clock behind a start/done handshake.
// Define SEQ_MULT_SIGNED_EN to honour signed_mode. Otherwise every operation is unsigned.
module seq_shift_add_multiplier #(
  parameter int WIDTH = 8
) (
  input logic                     clk,
  input logic                     rst,
  seq_shift_add_multiplier_if.slave bus
);

  localparam int CNT_W = $clog2(WIDTH);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(WIDTH - 1);

  typedef enum logic [1:0] {
    IDLE,
    CALC,
    FIX
  } state_t;

  state_t state;
  state_t next_state;

  logic [2*WIDTH-1:0] mcand;
  logic [WIDTH-1:0]   mplier;
  logic [2*WIDTH-1:0] acc;
  logic [CNT_W-1:0]   cnt;
  logic               neg_flag;
  logic [2*WIDTH-1:0] product;
  logic               done;
  logic               busy;

  logic [WIDTH-1:0]   mag_a;
  logic [WIDTH-1:0]   mag_b;
  logic               neg_in;

`ifdef SEQ_MULT_SIGNED_EN
  // A magnitude of 2^(WIDTH-1) still fits in WIDTH unsigned bits, so the most negative operand is exact.
  assign mag_a  = (bus.signed_mode && bus.a[WIDTH-1]) ? -bus.a : bus.a;
  assign mag_b  = (bus.signed_mode && bus.b[WIDTH-1]) ? -bus.b : bus.b;
  assign neg_in = bus.signed_mode & (bus.a[WIDTH-1] ^ bus.b[WIDTH-1]);
`else
  logic unused_signed_mode;
  assign unused_signed_mode = bus.signed_mode;
  assign mag_a  = bus.a;
  assign mag_b  = bus.b;
  assign neg_in = 1'b0;
`endif

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= IDLE;
    else     state <= next_state;
  end

  always_comb begin
    next_state = state;
    case (state)
      IDLE:    if (bus.start) next_state = CALC;
      CALC:    if (cnt == CNT_LAST) next_state = FIX;
      FIX:     next_state = IDLE;
      default: next_state = IDLE;
    endcase
  end

  always_comb begin
    busy = (state != IDLE);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      mcand    <= '0;
      mplier   <= '0;
      acc      <= '0;
      cnt      <= '0;
      neg_flag <= 1'b0;
      product  <= '0;
      done     <= 1'b0;
    end else begin
      done <= 1'b0;
      case (state)
        IDLE: begin
          if (bus.start) begin
            mcand    <= {{WIDTH{1'b0}}, mag_a};
            mplier   <= mag_b;
            acc      <= '0;
            cnt      <= '0;
            neg_flag <= neg_in;
          end
        end
        CALC: begin
          if (mplier[0]) acc <= acc + mcand;
          mcand  <= mcand << 1;
          mplier <= mplier >> 1;
          cnt    <= cnt + 1'b1;
        end
        FIX: begin
          product <= neg_flag ? -acc : acc;
          done    <= 1'b1;
        end
        default: ;
      endcase
    end
  end

  assign bus.busy    = busy;
  assign bus.done    = done;
  assign bus.product = product;

endmodule

// File: tb/tb_seq_shift_add_multiplier.sv
// Bench for seq_shift_add_multiplier. It runs directed vectors and then random operands.
// The reference is plain integer multiplication.
module tb_seq_shift_add_multiplier;

  localparam int WIDTH = 8;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   compared = 0;
  int   mismatched = 0;

  seq_shift_add_multiplier_if #(.WIDTH(WIDTH)) bus ();

  seq_shift_add_multiplier #(.WIDTH(WIDTH)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus.slave)
  );

  always #5 clk = ~clk;

  function automatic logic [15:0] refProduct(input logic [7:0] x, input logic [7:0] y,
                                             input logic sm);
    int  sx;
    int  sy;
    logic use_signed;
`ifdef SEQ_MULT_SIGNED_EN
    use_signed = sm;
`else
    use_signed = sm & 1'b0;
`endif
    sx = use_signed ? int'($signed(x)) : int'(x);
    sy = use_signed ? int'($signed(y)) : int'(y);
    return 16'(sx * sy);
  endfunction

  task automatic checkOutput(input string tag, input logic [31:0] observed,
                             input logic [31:0] expected);
    compared++;
    assert (observed === expected) else begin
      mismatched++;
      $error("[TB] FAIL %s: observed 0x%0h expected 0x%0h", tag, observed, expected);
    end
  endtask

  // Called on a falling edge. Start is held across exactly one rising edge, and the operands are then scrambled.
  task automatic applyStimulus(input logic [7:0] x, input logic [7:0] y, input logic sm);
    bus.start       = 1'b1;
    bus.a           = x;
    bus.b           = y;
    bus.signed_mode = sm;
    @(negedge clk);
    bus.start       = 1'b0;
    bus.a           = 8'($urandom);
    bus.b           = 8'($urandom);
    bus.signed_mode = 1'($urandom);
  endtask

  task automatic waitDone(input string tag, input logic [15:0] expected);
    int lat;
    bit busy_ok;
    lat     = 0;
    busy_ok = 1'b1;
    while (bus.done !== 1'b1 && lat < 40) begin
      if (bus.busy !== 1'b1) busy_ok = 1'b0;
      @(negedge clk);
      lat++;
    end
    checkOutput({tag, " latency"}, lat, WIDTH + 1);
    checkOutput({tag, " busy_window"}, 32'(busy_ok), 1);
    checkOutput({tag, " product"}, bus.product, expected);
    checkOutput({tag, " busy_at_done"}, bus.busy, 0);
  endtask

  task automatic checkPulseEnd(input string tag);
    @(negedge clk);
    checkOutput({tag, " done_pulse"}, bus.done, 0);
  endtask

  initial begin
    int          dones;
    int          first_done;
    logic [15:0] captured;
    logic [7:0]  rx;
    logic [7:0]  ry;
    logic        rs;

    bus.start       = 1'b0;
    bus.a           = '0;
    bus.b           = '0;
    bus.signed_mode = 1'b0;
    repeat (2) @(negedge clk);
    checkOutput("reset busy", bus.busy, 0);
    checkOutput("reset done", bus.done, 0);
    checkOutput("reset product", bus.product, 0);
    rst = 1'b0;
    @(negedge clk);

    applyStimulus(8'd13, 8'd11, 1'b0);
    waitDone("13x11", 16'h008F);
    checkPulseEnd("13x11");

    applyStimulus(8'd255, 8'd255, 1'b0);
    waitDone("255x255", 16'hFE01);
    checkPulseEnd("255x255");

    applyStimulus(8'd0, 8'd200, 1'b0);
    waitDone("0x200", 16'h0000);
    checkPulseEnd("0x200");

    applyStimulus(8'd13, 8'd11, 1'b0);
    waitDone("b2b first", 16'h008F);
    applyStimulus(8'd2, 8'd3, 1'b0);
    waitDone("b2b second", 16'h0006);
    checkPulseEnd("b2b second");

`ifdef SEQ_MULT_SIGNED_EN
    applyStimulus(8'hFD, 8'h05, 1'b1);
    waitDone("s -3x5", 16'hFFF1);
    checkPulseEnd("s -3x5");
    applyStimulus(8'h80, 8'h80, 1'b1);
    waitDone("s -128x-128", 16'h4000);
    checkPulseEnd("s -128x-128");
    applyStimulus(8'h7F, 8'hFF, 1'b1);
    waitDone("s 127x-1", 16'hFF81);
    checkPulseEnd("s 127x-1");
    applyStimulus(8'hFD, 8'h05, 1'b0);
    waitDone("u FDx05", 16'h04F1);
    checkPulseEnd("u FDx05");
`else
    applyStimulus(8'hFD, 8'h05, 1'b1);
    waitDone("nosigned FDx05", 16'h04F1);
    checkPulseEnd("nosigned FDx05");
`endif

    // New starts arrive mid-operation and must be ignored.
    applyStimulus(8'h25, 8'h31, 1'b0);
    dones      = 0;
    first_done = 0;
    captured   = '0;
    for (int c = 1; c <= 12; c++) begin
      @(negedge clk);
      bus.start = (c == 2 || c == 7);
      if (bus.start) begin
        bus.a = 8'($urandom);
        bus.b = 8'($urandom);
      end
      if (bus.done === 1'b1) begin
        dones++;
        if (first_done == 0) begin
          first_done = c;
          captured   = bus.product;
        end
      end
    end
    bus.start = 1'b0;
    checkOutput("ignore done_count", dones, 1);
    checkOutput("ignore latency", first_done, WIDTH + 1);
    checkOutput("ignore product", captured, 16'h0715);

    // Reset arrives after four CALC edges, and product must clear at once.
    applyStimulus(8'd200, 8'd100, 1'b0);
    repeat (4) @(negedge clk);
    rst = 1'b1;
    #1;
    checkOutput("midreset busy", bus.busy, 0);
    checkOutput("midreset done", bus.done, 0);
    checkOutput("midreset product", bus.product, 0);
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    applyStimulus(8'd6, 8'd7, 1'b0);
    waitDone("after reset 6x7", 16'h002A);
    checkPulseEnd("after reset 6x7");

    repeat (24) begin
      rx = 8'($urandom);
      ry = 8'($urandom);
      rs = 1'($urandom);
      applyStimulus(rx, ry, rs);
      waitDone($sformatf("rand %0h*%0h s%0d", rx, ry, rs), refProduct(rx, ry, rs));
      checkPulseEnd("rand");
    end

    $display("[TB] *** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule

// File: doc/seq_shift_add_multiplier.md
# seq_shift_add_multiplier

Parametrised multi-cycle shift-add multiplier: the sequential, width-generic successor to the team's fixed 4-bit combinational array multiplier. It accepts two WIDTH-bit operands on a start pulse and iterates one partial product per clock. It returns a 2*WIDTH-bit product with a one-cycle done pulse. Optional signed (two's-complement) mode. Used wherever area matters more than latency, as a drop-in arithmetic unit behind a simple start/done handshake.

## Interface
- WIDTH, 8, operand width in bits; legal range WIDTH >= 2
- clk  input  1  single clock, all state updates on rising edge
- rst  input  1  asynchronous, active-high reset
- start  input  1  request; sampled only in IDLE
- a  input  WIDTH  multiplicand, sampled with start
- b  input  WIDTH  multiplier, sampled with start
- signed_mode  input  1  1 = operands/product two's complement; sampled with start
- busy  output  1  high while an operation is in flight
- done  output  1  one-cycle pulse when product is updated
- product  output  2*WIDTH  result; held until the next completion or reset

## Operation
- Reset values: busy=0, done=0, product=0, state=IDLE, internal accumulator/shift registers/counter=0.
- FSM states:
  - IDLE
  - CALC (exactly WIDTH cycles)
  - FIX (1 cycle)
- IDLE, start=1:
  - Latch magnitudes of a, b: if signed mode is active and operand MSB=1, store its two's-complement negation, else the raw value.
  - Latch neg_flag = signed-active & (a[MSB] ^ b[MSB]).
  - Clear accumulator and counter; go to CALC; busy=1.
- CALC, each cycle:
  - If multiplier LSB=1, accumulator += multiplicand (2*WIDTH-bit, zero-extended).
  - Multiplicand shifts left 1; multiplier shifts right 1; counter++.
  - Leave to FIX when counter reaches WIDTH-1.
- FIX:
  - product <= neg_flag ? -accumulator : accumulator (2*WIDTH bits, modulo 2^(2*WIDTH)).
  - done=1, busy=0, go to IDLE.
- done is high for exactly one cycle. It is low in all other states.
- Width rules:
  - Unsigned results are exact.
  - Signed results are exact for all inputs, including -2^(WIDTH-1) * -2^(WIDTH-1) = 2^(2*WIDTH-2). The magnitude 2^(WIDTH-1) fits in WIDTH unsigned bits.
  - A zero operand gives product 0 with neg_flag irrelevant, since -0 = 0.
- start while busy (CALC/FIX): ignored. No queuing, no effect on the current operation.
- start in the cycle done is high: accepted, because the state is IDLE.
- a, b and signed_mode may change freely after the start cycle without effect.
- rst asserted mid-operation: immediate return to reset values. The partial result is discarded and product is cleared to 0.

## Timing
- Start sampled at edge E0 → busy=1 after E0.
- CALC occupies edges E1..E(WIDTH).
- FIX at edge E(WIDTH+1): product valid and done=1 after E(WIDTH+1), busy=0 in the same cycle.
- Latency start→done = WIDTH+1 clocks. Throughput is one result per WIDTH+1 clocks with back-to-back starts.
- All outputs are registered; there are no combinational paths from inputs to outputs.

## Configuration
- SEQ_MULT_SIGNED_EN:
  - Defined: signed_mode is honoured as described; magnitude conversion and FIX negation logic are present.
  - Undefined: the signed_mode port still exists but is ignored; all operations are unsigned; neg_flag is tied to 0. FIX still costs one cycle, so latency is unchanged.

## Test plan
- WIDTH=8, unsigned 13*11 → product=0x008F, done high exactly 9 cycles after the start edge for one cycle, busy high for the 9 intervening cycles.
- Unsigned 255*255 → 0xFE01; 0*200 → 0x0000; back-to-back start in the done cycle with 2*3 → 0x0006 nine cycles later.
- Macro defined, signed_mode=1:
  - -3*5 (0xFD, 0x05) → 0xFFF1
  - -128*-128 (0x80, 0x80) → 0x4000
  - 127*-1 → 0xFF81
- Macro undefined, signed_mode=1, 0xFD*0x05 → 0x04F1 (1265, unsigned).
- start pulsed with new operands on cycles 3 and 8 of an operation in flight → ignored; the original product is delivered on time and only one done pulse occurs.
- rst asserted at cycle 4 of CALC → busy=0, done=0, product=0 immediately. A later start with 6*7 → 0x002A after 9 cycles.
